// File: rtl/m_frame_encoder_if.sv
// Command-frame encoder port bundle: request/fields from the source, byte strobe toward UART TX.
// slave = encoder side, master = command source / TX engine side.
interface m_frame_encoder_if;
  logic        i_send;
  logic [7:0]  i_cmdcode;
  logic [31:0] i_para_list;
  logic [2:0]  i_para_num;
  logic        i_tx_ready;
  logic        o_tx_en;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_send, i_cmdcode, i_para_list, i_para_num, i_tx_ready,
    output o_tx_en, o_tx_data, o_busy, o_done
  );

  modport master (
    output i_send, i_cmdcode, i_para_list, i_para_num, i_tx_ready,
    input  o_tx_en, o_tx_data, o_busy, o_done
  );
endinterface

// File: rtl/m_frame_encoder.sv
// Serialises 0x40,len,cmd,params,check toward UART TX; first strobe the cycle after accept, one per 2 cycles.
// Stalls on i_tx_ready low; check byte is the LEN..PARA sum when FRAME_CHECKSUM_EN is defined, else 0xBC.
module m_frame_encoder (
  input  logic           clk,
  input  logic           rst_n,
  m_frame_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HEAD, LEN, CMD, PARA, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic        guard;
  logic [1:0]  para_cnt, para_cnt_nxt;
  logic [1:0]  para_idx_inc;
  logic [7:0]  cmd_q;
  logic [31:0] para_q;
  logic [2:0]  num_q;
  logic [7:0]  tx_data_q, tx_data_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        accept, issue, byte_state, last_para;
  logic [7:0]  check_byte;

  function automatic logic [2:0] clamp_num(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'd4)  return 3'd4;
    return n;
  endfunction

  assign byte_state   = (state == HEAD) || (state == LEN) || (state == CMD) ||
                        (state == PARA) || (state == CHECK);
  assign issue        = byte_state && bus.i_tx_ready && !guard;
  assign accept       = (state == IDLE) && bus.i_send;
  assign last_para    = ({1'b0, para_cnt} == (num_q - 3'd1));
  assign para_idx_inc = para_cnt + 2'd1;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
    end else if (accept) begin
      acc_q <= 8'h00;
    end else if (issue && ((state == LEN) || (state == CMD) || (state == PARA))) begin
      acc_q <= acc_q + tx_data_q;
    end
  end

  // Folds in the final PARA byte, which is being issued in the same cycle the check is preloaded.
  assign check_byte = acc_q + tx_data_q;
`else
  assign check_byte = 8'hBC;
`endif

  // tx_data holds the byte of the current state; it is preloaded with the next byte on each issue.
  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = tx_data_q;
    para_cnt_nxt = para_cnt;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_send) begin
          state_nxt    = HEAD;
          tx_data_nxt  = 8'h40;
          para_cnt_nxt = 2'd0;
          busy_nxt     = 1'b1;
        end
      end
      HEAD: begin
        if (issue) begin
          state_nxt   = LEN;
          tx_data_nxt = {5'd0, num_q} + 8'd1;
        end
      end
      LEN: begin
        if (issue) begin
          state_nxt   = CMD;
          tx_data_nxt = cmd_q;
        end
      end
      CMD: begin
        if (issue) begin
          state_nxt    = PARA;
          tx_data_nxt  = para_q[7:0];
          para_cnt_nxt = 2'd0;
        end
      end
      PARA: begin
        if (issue) begin
          if (last_para) begin
            state_nxt   = CHECK;
            tx_data_nxt = check_byte;
          end else begin
            para_cnt_nxt = para_idx_inc;
            tx_data_nxt  = para_q[{para_idx_inc, 3'b000} +: 8];
          end
        end
      end
      CHECK: begin
        if (issue) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guard     <= 1'b0;
      para_cnt  <= 2'd0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard     <= issue;
      para_cnt  <= para_cnt_nxt;
      tx_data_q <= tx_data_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= 8'h00;
      para_q <= 32'h0;
      num_q  <= 3'd1;
    end else if (accept) begin
      cmd_q  <= bus.i_cmdcode;
      para_q <= bus.i_para_list;
      num_q  <= clamp_num(bus.i_para_num);
    end
  end

  assign bus.o_tx_en   = issue;
  assign bus.o_tx_data = tx_data_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;

endmodule

// File: doc/m_frame_encoder.md
# m_frame_encoder

Transmit-side command frame builder for the UART command path: the counterpart of the receive-side frame decoder. It accepts a command code plus up to four parameter bytes and serialises them as a byte stream for the UART byte transmitter. The frame layout is header 0x40, length, command, parameters (LSB first) and check. The block sits between the response/command source logic and the UART TX byte engine, and paces itself on the TX engine's ready signal.

## Interface
- No parameters; frame constants are fixed: header 0x40, tail constant 0xBC.
- One clock; reset is asynchronous and active-low.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_send  input  1  start request; sampled only in IDLE.
- i_cmdcode  input  8  command code; latched on an accepted i_send.
- i_para_list  input  32  parameter bytes; byte k = bits [8k+7:8k]; latched on accept.
- i_para_num  input  3  number of parameter bytes; latched on accept and clamped (0→1, 5..7→4).
- i_tx_ready  input  1  UART TX can accept a byte this cycle.
- o_tx_en  output  1  one-cycle byte strobe to UART TX.
- o_tx_data  output  8  byte presented with o_tx_en.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse after the check byte has been issued.

## Operation
- States: IDLE, HEAD, LEN, CMD, PARA, CHECK, DONE. The guard cycle below is a flag, not a state.
- IDLE:
  - i_send=1 latches the inputs, clears the PARA counter and the check accumulator, and moves to HEAD.
  - i_send in any other state is ignored; it is not queued.
- Byte issue rule:
  - In HEAD, LEN, CMD, PARA and CHECK, a byte is issued when i_tx_ready=1 and the guard flag is clear.
  - Issuing a byte means: o_tx_en=1 for one cycle, o_tx_data registered, guard flag set for the following cycle.
  - In the guard cycle, i_tx_ready is ignored. This gives the TX engine one cycle to drop ready.
- Byte sequence:
  - HEAD: 0x40.
  - LEN: P+1, where P is the clamped i_para_num (the length counts the command byte plus parameters).
  - CMD: latched cmdcode.
  - PARA: bytes 0..P-1 of the latched para_list, in ascending order. A 2-bit counter selects the byte; PARA→CHECK after byte P-1.
  - CHECK: check byte (see Configuration).
- Each state advances to the next on its byte issue. CHECK→DONE; DONE→IDLE unconditionally after one cycle.
- Check accumulator: 8-bit, modulo 256. It adds every issued LEN, CMD and PARA byte; the header is excluded.
- Reset values: o_tx_en=0, o_tx_data=0x00, o_busy=0, o_done=0, state=IDLE, guard=0, counters=0.
- Reset asserted mid-frame aborts the frame immediately with no further strobes; the truncated frame is left to the receiver's resync.

## Timing
- Accepting i_send at cycle t gives: o_busy=1 from t+1.
- With i_tx_ready held at 1, the HEAD strobe occurs at t+1, then one strobe every 2 cycles.
- The last (CHECK) strobe occurs at t+1+2(P+3). o_done=1 at the following cycle and o_busy=0 in that same cycle; the next cycle is IDLE, and a new i_send may be accepted there.
- i_tx_ready low stalls the current byte indefinitely. o_tx_data holds its last value and no strobe is issued.
- o_tx_en is never high on two consecutive cycles.
- Latched fields are immune to input changes after accept.

## Configuration
- Macro FRAME_CHECKSUM_EN.
  - Defined: the CHECK byte is the 8-bit sum accumulator.
  - Undefined: the CHECK byte is the constant 0xBC and the accumulator logic is omitted.
- Frame length and timing are identical in both builds.

## Test plan
- cmd=0x21, para=0x11223344, num=4, ready=1 → bytes 40 05 21 44 33 22 11 D0 (0xBC without macro); 8 strobes spaced 2 cycles; o_done one cycle after the last strobe.
- cmd=0x03, para=0x0000ABCD, num=2 → 40 03 03 CD AB 7E (0xBC without macro).
- num=0 → treated as 1: 40 02 cmd P0 chk. num=7 → treated as 4: LEN=0x05, four PARA bytes.
- ready toggled low for 5 cycles during CMD → the strobe is delayed until ready=1 and the guard is clear; the byte sequence is unchanged; no double strobe.
- i_send pulsed mid-frame and inputs changed after accept → frame unchanged; no second frame starts.
- rst_n low during PARA → all outputs at reset values within the same cycle; after release, IDLE; a fresh i_send produces a complete, correct frame.
